pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control block that drives the enable, flush and bubble inputs of the PC register and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, taken branches resolved in MEM, and data-memory wait states. Resolves them by stalling, bubbling or flushing stages.
- Keeps saturating stall/flush statistics counters and a data-memory timeout watchdog.

Parameters:
- CNT_W, 16, width of the statistics counters.
- TIMEOUT, 64, number of consecutive busy cycles in the MEM_WAIT state after which the error is raised; range 1..255.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- idex_memread_i  in  1  ID/EX control: the instruction in EX is a load
- idex_rd_i  in  5  ID/EX destination register
- ifid_rs1_i  in  5  rs1 field of the IF/ID instruction
- ifid_rs2_i  in  5  rs2 field of the IF/ID instruction
- ifid_uses_rs2_i  in  1  the IF/ID instruction reads rs2
- exmem_branch_taken_i  in  1  EX/MEM membranch AND zero
- dmem_busy_i  in  1  data memory not ready this cycle
- pc_en_o  out  1  PC register enable
- pc_sel_branch_o  out  1  PC loads the branch target instead of PC+4
- ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o  out  1 each  pipeline register enables
- ifid_flush_o  out  1  IF/ID loads a NOP (32'h0000_0013)
- idex_bubble_o  out  1  ID/EX loads all control bits as 0
- exmem_flush_o  out  1  EX/MEM loads all control bits as 0
- stall_cnt_o  out  CNT_W  cycles spent stalled (load-use plus mem-wait)
- flush_cnt_o  out  CNT_W  number of branch flushes
- err_timeout_o  out  1  sticky data-memory timeout error

Behaviour:
- Reset (arst_n=0, async):
  - state=RUN, counters=0, wait_cnt=0, err_timeout_o=0.
  - All enables are 0 while reset is asserted. Flush, bubble and sel outputs are 0.
- Control outputs are combinational from the current state and inputs, so they act in the same cycle as detection. State, counters and err are registered.
- load_use = idex_memread_i & (idex_rd_i!=0) & ((idex_rd_i==ifid_rs1_i) | (ifid_uses_rs2_i & idex_rd_i==ifid_rs2_i)).
- Per-cycle priority, highest first:
  1. state ERROR: all enables 0, no flush/bubble. Persists until reset.
  2. dmem_busy_i=1: all enables 0 (full freeze); branch and load_use are ignored this cycle.
  3. exmem_branch_taken_i=1:
     - all enables 1, pc_sel_branch_o=1;
     - ifid_flush_o, idex_bubble_o and exmem_flush_o all 1;
     - flush_cnt +1.
     - Overrides load_use.
  4. load_use=1 and state!=LD_STALL:
     - pc_en_o=0, ifid_en_o=0;
     - idex_en_o=1 with idex_bubble_o=1;
     - exmem_en_o=1, memwb_en_o=1;
     - stall_cnt +1.
  5. Otherwise: all enables 1, all flush/bubble/sel outputs 0.
- FSM states: RUN, LD_STALL, MEM_WAIT, ERROR.
  - RUN → MEM_WAIT on dmem_busy_i.
  - RUN → LD_STALL on priority-4 stall.
  - LD_STALL → RUN after exactly 1 cycle, or → MEM_WAIT if dmem_busy_i. While in LD_STALL, load_use is ignored, which guarantees a single bubble per hazard.
  - MEM_WAIT:
    - each busy cycle increments wait_cnt and stall_cnt;
    - on !dmem_busy_i: wait_cnt clears, and the block applies rules 3–5 that same cycle and goes to RUN;
    - when wait_cnt reaches TIMEOUT with busy still 1: → ERROR, err_timeout_o=1.
  - Entry into MEM_WAIT from RUN or LD_STALL counts as the first busy cycle (stall_cnt +1, wait_cnt=1).
- Counters saturate at all-ones and never wrap. wait_cnt is 8-bit internal.
- Reset asserted mid-stall or mid-wait: immediate return to the reset values above. There is no pending state.

Decomposition:
- Shared package holds:
  - the FSM state enum (2-bit);
  - the NOP encoding constant 32'h0000_0013;
  - the register index width constant (5).
- One sub-module: sat_counter (parameter W; ports clk, arst_n, inc, count). Instanced for stall_cnt and flush_cnt.

Test Plan:
- Reset then idle inputs → all enables 1, flushes 0, counters 0, err 0.
- Load-use: memread=1, rd=5, rs1=5, held 2 cycles → exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1; second cycle all enables 1; stall_cnt=1.
- Load-use on rs2 with ifid_uses_rs2_i=0, and a separate case with rd=0 → no stall.
- Branch taken and load_use in the same cycle → flush wins: pc_sel_branch=1, all three flushes 1, flush_cnt=1, stall_cnt=0.
- dmem_busy for 3 cycles while branch_taken=1 → 3 cycles with all enables 0; 4th cycle flush asserted; stall_cnt=3, flush_cnt=1.
- TIMEOUT=4 with busy held high → err_timeout_o=1 after the 4th busy cycle, enables stay 0 after busy drops, and the block clears only on arst_n pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-control outputs of the hazard controller.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic                 idex_memread_i;
  logic [REG_IDX_W-1:0] idex_rd_i;
  logic [REG_IDX_W-1:0] ifid_rs1_i;
  logic [REG_IDX_W-1:0] ifid_rs2_i;
  logic                 ifid_uses_rs2_i;
  logic                 exmem_branch_taken_i;
  logic                 dmem_busy_i;
  logic                 pc_en_o;
  logic                 pc_sel_branch_o;
  logic                 ifid_en_o;
  logic                 idex_en_o;
  logic                 exmem_en_o;
  logic                 memwb_en_o;
  logic                 ifid_flush_o;
  logic                 idex_bubble_o;
  logic                 exmem_flush_o;
  logic [CNT_W-1:0]     stall_cnt_o;
  logic [CNT_W-1:0]     flush_cnt_o;
  logic                 err_timeout_o;

  modport master (
    output idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i,
           exmem_branch_taken_i, dmem_busy_i,
    input  pc_en_o, pc_sel_branch_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
           ifid_flush_o, idex_bubble_o, exmem_flush_o, stall_cnt_o, flush_cnt_o,
           err_timeout_o
  );

  modport slave (
    input  idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i,
           exmem_branch_taken_i, dmem_busy_i,
    output pc_en_o, pc_sel_branch_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
           ifid_flush_o, idex_bubble_o, exmem_flush_o, stall_cnt_o, flush_cnt_o,
           err_timeout_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count up on inc until saturated.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= {W{1'b0}};
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory
// freeze with timeout watchdog, and saturating stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               arst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic             r_err;
  logic [7:0]       w_wait_next;
  logic             w_load_use;
  logic             w_ld_stall;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [8:0]       w_ctrl;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  assign w_load_use = bus.idex_memread_i && (bus.idex_rd_i != 5'd0) &&
                      ((bus.idex_rd_i == bus.ifid_rs1_i) ||
                       (bus.ifid_uses_rs2_i && (bus.idex_rd_i == bus.ifid_rs2_i)));

  // Entering MEM_WAIT counts as the first busy cycle.
  assign w_wait_next = (r_state == ST_MEM_WAIT) ? (r_wait_cnt + 8'd1) : 8'd1;

  // Control decode; w_ctrl = {pc_en, sel, ifid_en, idex_en, exmem_en, memwb_en,
  // ifid_flush, idex_bubble, exmem_flush}.
  always_comb begin
    w_ctrl      = 9'b0_0000_0000;
    w_ld_stall  = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (arst_n && (r_state != ST_ERROR)) begin
      if (bus.dmem_busy_i) begin
        w_stall_inc = 1'b1;
      end else if (bus.exmem_branch_taken_i) begin
        w_ctrl      = 9'b1_1111_1111;
        w_flush_inc = 1'b1;
      end else if (w_load_use && (r_state != ST_LD_STALL)) begin
        w_ctrl      = 9'b0_0011_1010;
        w_ld_stall  = 1'b1;
        w_stall_inc = 1'b1;
      end else begin
        w_ctrl      = 9'b1_0111_1000;
      end
    end else begin
      w_ctrl = 9'b0_0000_0000;
    end
  end

  // Hazard FSM, wait-state watchdog and sticky timeout error.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_LD_STALL, ST_MEM_WAIT: begin
          if (bus.dmem_busy_i) begin
            r_wait_cnt <= w_wait_next;
            if (w_wait_next >= L_TIMEOUT) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_MEM_WAIT;
            end
          end else begin
            r_wait_cnt <= 8'd0;
            r_state    <= ((r_state == ST_RUN) && w_ld_stall) ? ST_LD_STALL : ST_RUN;
          end
        end
        default: begin
          r_state <= ST_ERROR;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (w_stall_inc),
    .count  (w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (w_flush_inc),
    .count  (w_flush_cnt)
  );

  assign {bus.pc_en_o, bus.pc_sel_branch_o, bus.ifid_en_o, bus.idex_en_o,
          bus.exmem_en_o, bus.memwb_en_o, bus.ifid_flush_o, bus.idex_bubble_o,
          bus.exmem_flush_o} = w_ctrl;
  assign bus.stall_cnt_o   = w_stall_cnt;
  assign bus.flush_cnt_o   = w_flush_cnt;
  assign bus.err_timeout_o = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared every cycle against a rule-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  localparam logic [8:0] C_OFF    = 9'b0_0000_0000;
  localparam logic [8:0] C_IDLE   = 9'b1_0111_1000;
  localparam logic [8:0] C_BRANCH = 9'b1_1111_1111;
  localparam logic [8:0] C_BUBBLE = 9'b0_0011_1010;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: error flag, consecutive busy count, "bubble just issued"
  // guard, whether last cycle was busy, and the two statistics.
  bit m_err, m_guard, m_prev_busy;
  int m_run, m_stall, m_flush;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_ctrl();
    return {bus.pc_en_o, bus.pc_sel_branch_o, bus.ifid_en_o, bus.idex_en_o,
            bus.exmem_en_o, bus.memwb_en_o, bus.ifid_flush_o, bus.idex_bubble_o,
            bus.exmem_flush_o};
  endfunction

  function automatic bit model_lu();
    return bus.idex_memread_i && (bus.idex_rd_i != 5'd0) &&
           ((bus.idex_rd_i == bus.ifid_rs1_i) ||
            (bus.ifid_uses_rs2_i && (bus.idex_rd_i == bus.ifid_rs2_i)));
  endfunction

  function automatic logic [8:0] exp_ctrl();
    if (!arst_n || m_err || bus.dmem_busy_i) return C_OFF;
    if (bus.exmem_branch_taken_i) return C_BRANCH;
    if (model_lu() && !m_guard) return C_BUBBLE;
    return C_IDLE;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_err = 0; m_guard = 0; m_prev_busy = 0; m_run = 0; m_stall = 0; m_flush = 0;
  endtask

  // Apply the clock edge that just happened, using the inputs that were held across it.
  task automatic model_advance();
    bit bubble;
    if (!arst_n) begin
      model_reset();
    end else if (!m_err) begin
      if (bus.dmem_busy_i) begin
        m_run++;
        m_stall = sat_inc(m_stall);
        if (m_run >= TIMEOUT) m_err = 1;
        m_guard = 0;
      end else begin
        bubble = !bus.exmem_branch_taken_i && model_lu() && !m_guard;
        if (bus.exmem_branch_taken_i) m_flush = sat_inc(m_flush);
        if (bubble) m_stall = sat_inc(m_stall);
        m_guard = bubble && !m_prev_busy;
        m_run = 0;
      end
      m_prev_busy = bus.dmem_busy_i;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ctrl", {23'd0, dut_ctrl()}, {23'd0, exp_ctrl()});
    check("stall_cnt", {16'd0, bus.stall_cnt_o}, m_stall);
    check("flush_cnt", {16'd0, bus.flush_cnt_o}, m_flush);
    check("err_timeout", {31'd0, bus.err_timeout_o}, {31'd0, m_err});
  end

  task automatic put(input bit mr, input int rd, input int rs1, input int rs2,
                     input bit uses, input bit br, input bit busy);
    bus.idex_memread_i       = mr;
    bus.idex_rd_i            = 5'(rd);
    bus.ifid_rs1_i           = 5'(rs1);
    bus.ifid_rs2_i           = 5'(rs2);
    bus.ifid_uses_rs2_i      = uses;
    bus.exmem_branch_taken_i = br;
    bus.dmem_busy_i          = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    model_reset();
    put(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_ctrl", {23'd0, dut_ctrl()}, 32'd0);
    check("rst_stall", {16'd0, bus.stall_cnt_o}, 32'd0);
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    put(0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset();
    #1;
    check("idle_ctrl", {23'd0, dut_ctrl()}, {23'd0, C_IDLE});
    check("idle_err", {31'd0, bus.err_timeout_o}, 32'd0);

    // Load-use held for two cycles gives exactly one bubble.
    put(1, 5, 5, 0, 0, 0, 0);
    #1;
    check("lu_bubble", {23'd0, dut_ctrl()}, {23'd0, C_BUBBLE});
    tick();
    check("lu_second", {23'd0, dut_ctrl()}, {23'd0, C_IDLE});
    check("lu_stall1", {16'd0, bus.stall_cnt_o}, 32'd1);
    tick();
    put(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("lu_stall_hold", {16'd0, bus.stall_cnt_o}, 32'd1);

    // rs2 match without rs2 use, and rd=x0: no hazard.
    put(1, 7, 0, 7, 0, 0, 0);
    #1;
    check("rs2_unused", {23'd0, dut_ctrl()}, {23'd0, C_IDLE});
    put(1, 0, 0, 0, 1, 0, 0);
    #1;
    check("rd_zero", {23'd0, dut_ctrl()}, {23'd0, C_IDLE});
    tick();
    check("no_stall", {16'd0, bus.stall_cnt_o}, 32'd1);

    // Branch beats load-use.
    do_reset();
    put(1, 5, 5, 0, 0, 1, 0);
    #1;
    check("br_lu_ctrl", {23'd0, dut_ctrl()}, {23'd0, C_BRANCH});
    tick();
    check("br_flush1", {16'd0, bus.flush_cnt_o}, 32'd1);
    check("br_stall0", {16'd0, bus.stall_cnt_o}, 32'd0);

    // Busy freezes a pending branch for three cycles.
    do_reset();
    put(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_freeze", {23'd0, dut_ctrl()}, 32'd0);
      tick();
    end
    put(0, 0, 0, 0, 0, 1, 0);
    #1;
    check("busy_release", {23'd0, dut_ctrl()}, {23'd0, C_BRANCH});
    tick();
    check("busy_stall3", {16'd0, bus.stall_cnt_o}, 32'd3);
    check("busy_flush1", {16'd0, bus.flush_cnt_o}, 32'd1);

    // Timeout after the TIMEOUT-th busy cycle; sticky until reset.
    do_reset();
    put(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("to_not_yet", {31'd0, bus.err_timeout_o}, 32'd0);
    tick();
    check("to_err", {31'd0, bus.err_timeout_o}, 32'd1);
    put(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("to_frozen", {23'd0, dut_ctrl()}, 32'd0);
    check("to_sticky", {31'd0, bus.err_timeout_o}, 32'd1);
    do_reset();
    #1;
    check("to_cleared", {31'd0, bus.err_timeout_o}, 32'd0);
    check("to_ctrl_ok", {23'd0, dut_ctrl()}, {23'd0, C_IDLE});

    // Random traffic with periodic resets.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        put($urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0),
            $urandom_range(3, 0), $urandom_range(1, 0),
            ($urandom_range(7, 0) == 0), ($urandom_range(5, 0) == 0));
        tick();
      end
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
